// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with return-address stack and redirect pulse.
// Optional: define PC_STACK_ERR_HALT_EN to halt on stack errors.
module fetch_pc_unit #(
   parameter int unsigned PC_W        = 12,
   parameter int unsigned OFF_W       = 8,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_pc,
   input  logic             stall,
   input  logic [1:0]       instSel,
   input  logic             push,
   input  logic             pop,
   input  logic [OFF_W-1:0] branch_off,
   input  logic [PC_W-1:0]  jump_addr,
   input  logic             clr_err,
   output logic [PC_W-1:0]  pc,
   output logic             redirect,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err,
   output logic             halted
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   localparam logic [0:0] RUN = 1'b0;
`ifdef PC_STACK_ERR_HALT_EN
   localparam logic [0:0] HALT = 1'b1;
`endif

   logic [0:0]       state;
   logic [0:0]       state_n;
   logic [SP_W-1:0]  sp;
   logic [SP_W-1:0]  sp_n;
   logic [PC_W-1:0]  pc_n;
   logic [PC_W-1:0]  pc_inc;
   logic             redirect_n;
   logic             err_n;
   logic             err_evt;
   logic             wr_en;
   logic             upd;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;
   logic [PC_W-1:0]  stack [STACK_DEPTH];

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign pc_inc      = pc + PC_W'(1);
   assign wr_idx      = sp[IDX_W-1:0];
   assign top_idx     = IDX_W'(sp - SP_W'(1));
   assign upd         = (state == RUN) && ld_pc && !stall;

`ifdef PC_STACK_ERR_HALT_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   // Next-PC selection: push+pop collapses to push, then pop, then instSel.
   always_comb begin
      pc_n       = pc;
      sp_n       = sp;
      redirect_n = 1'b0;
      err_evt    = 1'b0;
      wr_en      = 1'b0;
      state_n    = state;
      if (upd) begin
         if (push) begin
            pc_n       = jump_addr;
            redirect_n = 1'b1;
            if (pop || stack_full) err_evt = 1'b1;
            if (!stack_full) begin
               wr_en = 1'b1;
               sp_n  = sp + SP_W'(1);
            end
         end else if (pop) begin
            if (stack_empty) begin
               err_evt = 1'b1;
               pc_n    = pc_inc;
            end else begin
               pc_n       = stack[top_idx];
               sp_n       = sp - SP_W'(1);
               redirect_n = 1'b1;
            end
         end else begin
            case (instSel)
               2'b00: begin
                  pc_n       = pc + PC_W'($signed(branch_off));
                  redirect_n = 1'b1;
               end
               2'b10: begin
                  pc_n       = jump_addr;
                  redirect_n = 1'b1;
               end
               default: pc_n = pc_inc;
            endcase
         end
      end
`ifdef PC_STACK_ERR_HALT_EN
      // An erroneous cycle freezes everything and parks the unit.
      if (err_evt) begin
         pc_n       = pc;
         sp_n       = sp;
         wr_en      = 1'b0;
         redirect_n = 1'b0;
         state_n    = HALT;
      end
`endif
      if (err_evt)      err_n = 1'b1;
      else if (clr_err) err_n = 1'b0;
      else              err_n = stack_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         pc        <= '0;
         sp        <= '0;
         redirect  <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         sp        <= sp_n;
         redirect  <= redirect_n;
         stack_err <= err_n;
      end
   end

   // Stack storage needs no reset; contents are only read below sp.
   always_ff @(posedge clk) begin
      if (wr_en) stack[wr_idx] <= pc_inc;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: vector table plus call/return, error and reset sequences.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_pc;
   logic        stall;
   logic [1:0]  instSel;
   logic        push;
   logic        pop;
   logic [7:0]  branch_off;
   logic [11:0] jump_addr;
   logic        clr_err;
   logic [11:0] pc;
   logic        redirect;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        ld, st;
      logic [1:0]  is;
      logic        pu, po;
      logic [7:0]  off;
      logic [11:0] ja;
      logic        clr;
      logic [11:0] epc;
      logic        er, ee, em, ef, eh;
   } vec_t;

   typedef struct {
      logic [11:0] epc;
      logic        er, ee, em, ef, eh;
   } exp_t;

   exp_t exp_q[$];

   fetch_pc_unit dut (
      .clk(clk), .rst(rst), .ld_pc(ld_pc), .stall(stall), .instSel(instSel),
      .push(push), .pop(pop), .branch_off(branch_off), .jump_addr(jump_addr),
      .clr_err(clr_err), .pc(pc), .redirect(redirect), .stack_full(stack_full),
      .stack_empty(stack_empty), .stack_err(stack_err), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t v(input logic ld, st, input logic [1:0] is, input logic pu, po,
                              input logic [7:0] off, input logic [11:0] ja, input logic clr,
                              input logic [11:0] epc, input logic er, ee, em, ef, eh);
      vec_t r;
      r.ld = ld; r.st = st; r.is = is; r.pu = pu; r.po = po; r.off = off; r.ja = ja;
      r.clr = clr; r.epc = epc; r.er = er; r.ee = ee; r.em = em; r.ef = ef; r.eh = eh;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".pc"},       32'(pc),          32'(e.epc));
      chk({tag, ".redirect"}, 32'(redirect),    32'(e.er));
      chk({tag, ".err"},      32'(stack_err),   32'(e.ee));
      chk({tag, ".empty"},    32'(stack_empty), 32'(e.em));
      chk({tag, ".full"},     32'(stack_full),  32'(e.ef));
      chk({tag, ".halted"},   32'(halted),      32'(e.eh));
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input string tag, input vec_t t);
      exp_t e;
      ld_pc = t.ld; stall = t.st; instSel = t.is; push = t.pu; pop = t.po;
      branch_off = t.off; jump_addr = t.ja; clr_err = t.clr;
      e.epc = t.epc; e.er = t.er; e.ee = t.ee; e.em = t.em; e.ef = t.ef; e.eh = t.eh;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s.queue: got empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check_all(tag, e);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ld_pc = 0; stall = 0; instSel = 2'b01; push = 0; pop = 0;
      branch_off = '0; jump_addr = '0; clr_err = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   vec_t tbl[15];
   exp_t er;

   initial begin
      tbl[0]  = v(1,0,2'b10,0,0,8'h00,12'hFFE,0, 12'hFFE,1,0,1,0,0);
      tbl[1]  = v(1,0,2'b01,0,0,8'h00,12'h000,0, 12'hFFF,0,0,1,0,0);
      tbl[2]  = v(1,0,2'b01,0,0,8'h00,12'h000,0, 12'h000,0,0,1,0,0);
      tbl[3]  = v(1,0,2'b01,0,0,8'h00,12'h000,0, 12'h001,0,0,1,0,0);
      tbl[4]  = v(0,0,2'b10,0,0,8'h00,12'h123,0, 12'h001,0,0,1,0,0);
      tbl[5]  = v(1,0,2'b10,0,0,8'h00,12'h020,0, 12'h020,1,0,1,0,0);
      tbl[6]  = v(1,1,2'b00,0,0,8'hF8,12'h000,0, 12'h020,0,0,1,0,0);
      tbl[7]  = v(1,0,2'b00,0,0,8'hF8,12'h000,0, 12'h018,1,0,1,0,0);
      tbl[8]  = v(1,0,2'b01,0,0,8'hF8,12'h000,0, 12'h019,0,0,1,0,0);
      tbl[9]  = v(1,0,2'b10,0,0,8'h00,12'h010,0, 12'h010,1,0,1,0,0);
      tbl[10] = v(1,0,2'b01,1,0,8'h00,12'h200,0, 12'h200,1,0,0,0,0);
      tbl[11] = v(1,0,2'b01,0,1,8'h00,12'h000,0, 12'h011,1,0,1,0,0);
      tbl[12] = v(1,0,2'b11,0,0,8'h00,12'h000,0, 12'h012,0,0,1,0,0);
      tbl[13] = v(1,0,2'b00,0,0,8'h7F,12'h000,0, 12'h091,1,0,1,0,0);
      tbl[14] = v(1,0,2'b10,0,0,8'h00,12'h040,0, 12'h040,1,0,1,0,0);

      do_reset();
      #1;
      er.epc = 12'h000; er.er = 0; er.ee = 0; er.em = 1; er.ef = 0; er.eh = 0;
      check_all("reset", er);

      for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tbl[i]);

`ifdef PC_STACK_ERR_HALT_EN
      step("underflow", v(1,0,2'b01,0,1,8'h00,12'h000,0, 12'h040,0,1,1,0,1));
      step("halt_hold", v(1,0,2'b10,0,0,8'h00,12'h555,0, 12'h040,0,1,1,0,1));
      do_reset();
      step("pp_jump",   v(1,0,2'b10,0,0,8'h00,12'h050,0, 12'h050,1,0,1,0,0));
      step("push_pop",  v(1,0,2'b01,1,1,8'h00,12'h080,0, 12'h050,0,1,1,0,1));
`else
      step("underflow", v(1,0,2'b01,0,1,8'h00,12'h000,0, 12'h041,0,1,1,0,0));
      step("clr_err",   v(0,0,2'b01,0,0,8'h00,12'h000,1, 12'h041,0,0,1,0,0));
      step("push_pop",  v(1,0,2'b01,1,1,8'h00,12'h080,0, 12'h080,1,1,0,0,0));
      step("clr_pop",   v(1,0,2'b01,0,1,8'h00,12'h000,1, 12'h042,1,0,1,0,0));
`endif

      // Fill the stack, then overflow it.
      do_reset();
      step("ovf_jump", v(1,0,2'b10,0,0,8'h00,12'h100,0, 12'h100,1,0,1,0,0));
      for (int i = 0; i < 8; i++)
         step($sformatf("push%0d", i),
              v(1,0,2'b01,1,0,8'h00,12'h200 + 12'(i),0, 12'h200 + 12'(i),1,0,0,(i == 7),0));
`ifdef PC_STACK_ERR_HALT_EN
      step("ovf",      v(1,0,2'b01,1,0,8'h00,12'h300,0, 12'h207,0,1,0,1,1));
      step("ovf_hold", v(1,0,2'b01,0,0,8'h00,12'h000,0, 12'h207,0,1,0,1,1));
      do_reset();
`else
      step("ovf",     v(1,0,2'b01,1,0,8'h00,12'h300,0, 12'h300,1,1,0,1,0));
      step("ovf_clr", v(0,0,2'b01,0,0,8'h00,12'h000,1, 12'h300,0,0,0,1,0));
      for (int k = 0; k < 8; k++)
         step($sformatf("ret%0d", k),
              v(1,0,2'b01,0,1,8'h00,12'h000,0, (k < 7) ? 12'h207 - 12'(k) : 12'h101,1,0,(k == 7),0,0));
      step("after_ret", v(1,0,2'b01,0,0,8'h00,12'h000,0, 12'h102,0,0,1,0,0));
`endif

      // Asynchronous reset away from any clock edge.
      step("pre_rst",  v(1,0,2'b10,0,0,8'h00,12'h05A,0, 12'h05A,1,0,1,0,0));
      step("pre_rst2", v(1,0,2'b01,1,0,8'h00,12'h0AA,0, 12'h0AA,1,0,0,0,0));
      #2;
      rst = 1'b0;
      #1;
      er.epc = 12'h000; er.er = 0; er.ee = 0; er.em = 1; er.ef = 0; er.eh = 0;
      check_all("async_rst", er);
      rst = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
